ram_responder: RTL and testbench



---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_responder_if.sv | 34 +++
 rtl/ram_responder_ram_array.sv | 45 ++++
 rtl/ram_responder.sv | 167 ++++++++++++++++
 tb/tb_ram_responder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// ram_pkg
// Shared definitions for the CPU-RAM request interface. Imported by the RAM
// responder, its interface, the core's memory controller and the benches.
//   ramstate_t     : progress code reported on ramstate
//   RAM_WORD_BYTES : bytes per array word (byte address -> word index shift)
//   RAM_LAT_MAX    : largest access latency the 4-bit counter can express
package ram_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int unsigned RAM_WORD_BYTES = 4;
    localparam int unsigned RAM_LAT_MAX    = 15;

endpackage

// File: rtl/ram_responder_if.sv
// ram_responder_if
// CPU-RAM request bundle between the core's memory controller (master) and
// the RAM responder (slave).
//   memaddr  : byte address (master -> slave)
//   memstore : write data   (master -> slave)
//   memREN   : read request, level-held until ACCESS
//   memWEN   : write request, level-held until ACCESS
//   ramload  : registered read data (slave -> master)
//   ramstate : registered progress code (slave -> master)
interface ram_responder_if
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    logic [ADDR_W-1:0] memaddr;
    logic [DATA_W-1:0] memstore;
    logic              memREN;
    logic              memWEN;
    logic [DATA_W-1:0] ramload;
    ramstate_t         ramstate;

    modport master (
        output memaddr, memstore, memREN, memWEN,
        input  ramload, ramstate
    );

    modport slave (
        input  memaddr, memstore, memREN, memWEN,
        output ramload, ramstate
    );

endinterface

// File: rtl/ram_responder_ram_array.sv
// ram_array
// Single-port DEPTH_WORDS x DATA_W storage with synchronous write and a
// registered synchronous read. Only the read register is reset; the array
// contents are not.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset of the read register
//   we_i    : write addr_i with wdata_i at this edge
//   re_i    : load rdata_o from addr_i at this edge
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read data, holds between reads
module ram_array #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// ram_responder
// Memory-side responder for the CPU-RAM request interface. Services level-held
// read/write requests from a word-addressed on-chip array with a fixed
// latency of LAT cycles (1..15) and reports progress on ramstate.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset (state FREE, ramload 0)
//   bus : ram_responder_if.slave (memaddr, memstore, memREN, memWEN in;
//         ramload, ramstate out)
// Optional build macro RAM_ADDR_CHECK_EN: a word index >= DEPTH_WORDS enters
// ERROR instead of wrapping modulo DEPTH_WORDS.
module ram_responder
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LAT         = 2
) (
    input  logic CLK,
    input  logic RST,
    ram_responder_if.slave bus
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_RELOAD = 4'(LAT - 1);

    ramstate_t         state_q,     state_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic [ADDR_W-1:0] snap_addr_q, snap_addr_d;
    logic              snap_ren_q,  snap_ren_d;
    logic              snap_wen_q,  snap_wen_d;

    logic              req;
    logic              both;
    logic              oor;
    logic              same;
    logic              commit;
    ramstate_t         start_state;
    logic              start_commit;
    logic [DATA_W-1:0] rdata;

    assign req  = bus.memREN ^ bus.memWEN;
    assign both = bus.memREN & bus.memWEN;
    assign same = (bus.memaddr == snap_addr_q) &&
                  (bus.memREN  == snap_ren_q)  &&
                  (bus.memWEN  == snap_wen_q);

`ifdef RAM_ADDR_CHECK_EN
    generate
        if (ADDR_W > IDX_W + 2) begin : g_range_chk
            assign oor = |bus.memaddr[ADDR_W-1:IDX_W+2];
        end else begin : g_range_full
            assign oor = 1'b0;
        end
    endgenerate
`else
    assign oor = 1'b0;
`endif

    // Outcome of sampling the inputs as a fresh request. Shared by FREE,
    // ACCESS and the restart path out of BUSY.
    always_comb begin : start_eval
        start_state  = FREE;
        start_commit = 1'b0;
        if (both) begin
            start_state = ERROR;
        end else if (req) begin
            if (oor) begin
                start_state = ERROR;
            end else if (LAT == 1) begin
                start_state  = ACCESS;
                start_commit = 1'b1;
            end else begin
                start_state = BUSY;
            end
        end
    end

    always_comb begin : next_eval
        state_d     = state_q;
        cnt_d       = cnt_q;
        snap_addr_d = snap_addr_q;
        snap_ren_d  = snap_ren_q;
        snap_wen_d  = snap_wen_q;
        commit      = 1'b0;
        unique case (state_q)
            FREE, ACCESS: begin
                state_d     = start_state;
                commit      = start_commit;
                cnt_d       = (start_state == BUSY) ? CNT_RELOAD : '0;
                snap_addr_d = bus.memaddr;
                snap_ren_d  = bus.memREN;
                snap_wen_d  = bus.memWEN;
            end
            BUSY: begin
                if (both) begin
                    state_d = ERROR;
                    cnt_d   = '0;
                end else if (!req) begin
                    state_d = FREE;
                    cnt_d   = '0;
                end else if (!same) begin
                    // Changed request: treat this edge as a brand-new start.
                    state_d     = start_state;
                    commit      = start_commit;
                    cnt_d       = (start_state == BUSY) ? CNT_RELOAD : '0;
                    snap_addr_d = bus.memaddr;
                    snap_ren_d  = bus.memREN;
                    snap_wen_d  = bus.memWEN;
                end else if (cnt_q == 4'd1) begin
                    state_d = ACCESS;
                    commit  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ERROR: begin
                if (both || (req && oor)) begin
                    state_d = ERROR;
                end else begin
                    state_d = FREE;
                end
            end
            default: begin
                state_d = FREE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= FREE;
            cnt_q       <= '0;
            snap_addr_q <= '0;
            snap_ren_q  <= 1'b0;
            snap_wen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            snap_addr_q <= snap_addr_d;
            snap_ren_q  <= snap_ren_d;
            snap_wen_q  <= snap_wen_d;
        end
    end

    // A commit only happens with exactly one enable high, so the enables
    // select read or write directly. RST suppresses a same-edge write.
    ram_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk_i   (CLK),
        .rst_i   (RST),
        .we_i    (commit & bus.memWEN & ~RST),
        .re_i    (commit & bus.memREN),
        .addr_i  (bus.memaddr[IDX_W+1:2]),
        .wdata_i (bus.memstore),
        .rdata_o (rdata)
    );

    assign bus.ramload  = rdata;
    assign bus.ramstate = state_q;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;
    import ram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] sb[$];
    logic [31:0] last_load;

    ram_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ram_responder #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .DEPTH_WORDS (1024),
        .LAT         (2)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input ramstate_t exp);
        check(tag, 32'(bus.ramstate), 32'(exp));
    endtask

    task automatic pop_load(input string tag);
        logic [31:0] e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected <scoreboard empty>", tag, bus.ramload);
        end else begin
            e = sb.pop_front();
            check(tag, bus.ramload, e);
            last_load = e;
        end
    endtask

    // Called in a FREE cycle; returns at the start of the FREE cycle after ACCESS.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input string tag);
        bus.memaddr  = addr;
        bus.memstore = data;
        bus.memWEN   = 1'b1;
        check_state({tag, "_free"}, FREE);
        tick();
        check_state({tag, "_busy"}, BUSY);
        tick();
        check_state({tag, "_access"}, ACCESS);
        bus.memWEN = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus.memaddr = addr;
        bus.memREN  = 1'b1;
        sb.push_back(exp);
        check_state({tag, "_free"}, FREE);
        tick();
        check_state({tag, "_busy"}, BUSY);
        tick();
        check_state({tag, "_access"}, ACCESS);
        pop_load({tag, "_data"});
        bus.memREN = 1'b0;
        tick();
    endtask

    initial begin
        bus.memaddr  = '0;
        bus.memstore = '0;
        bus.memREN   = 1'b0;
        bus.memWEN   = 1'b0;
        last_load    = '0;

        // Reset
        tick();
        tick();
        check_state("rst_state", FREE);
        check("rst_load", bus.ramload, 32'h0);
        rst = 1'b0;
        tick();

        // Preload words through the bus
        do_write(32'h10,   32'hDEADBEEF, "wr_w4");
        do_write(32'h14,   32'hCAFEF00D, "wr_w5");
        do_write(32'h0,    32'h5A5A0001, "wr_w0");
        do_write(32'h8,    32'h22222222, "wr_w2");

        // Read latency and write-then-read
        do_read(32'h10, 32'hDEADBEEF, "rd_lat");
        do_write(32'h20, 32'h12345678, "wr_w8");
        do_read(32'h20, 32'h12345678, "rd_w8");

        // Restart on address change in the BUSY cycle
        bus.memaddr = 32'h10;
        bus.memREN  = 1'b1;
        sb.push_back(32'hCAFEF00D);
        check_state("rs_c0", FREE);
        tick();
        check_state("rs_c1", BUSY);
        bus.memaddr = 32'h14;
        tick();
        check_state("rs_c2", BUSY);
        tick();
        check_state("rs_c3", ACCESS);
        pop_load("rs_data");
        bus.memREN = 1'b0;
        tick();

        // Illegal enables for 3 cycles
        bus.memaddr  = 32'h10;
        bus.memstore = 32'h0BADBAD0;
        bus.memREN   = 1'b1;
        bus.memWEN   = 1'b1;
        check_state("ill_c0", FREE);
        tick();
        check_state("ill_c1", ERROR);
        check("ill_load", bus.ramload, last_load);
        tick();
        check_state("ill_c2", ERROR);
        tick();
        check_state("ill_c3", ERROR);
        bus.memREN = 1'b0;
        bus.memWEN = 1'b0;
        tick();
        check_state("ill_c4", FREE);
        check("ill_load_end", bus.ramload, last_load);
        do_read(32'h10, 32'hDEADBEEF, "ill_rd");

        // Back-to-back reads with the request held through ACCESS
        bus.memaddr = 32'h14;
        bus.memREN  = 1'b1;
        sb.push_back(32'hCAFEF00D);
        sb.push_back(32'hCAFEF00D);
        check_state("b2b_c0", FREE);
        tick();
        check_state("b2b_c1", BUSY);
        tick();
        check_state("b2b_c2", ACCESS);
        pop_load("b2b_d0");
        tick();
        check_state("b2b_c3", BUSY);
        tick();
        check_state("b2b_c4", ACCESS);
        pop_load("b2b_d1");
        bus.memREN = 1'b0;
        tick();
        check_state("b2b_c5", FREE);

        // Out-of-range address
`ifdef RAM_ADDR_CHECK_EN
        bus.memaddr = 32'h1000;
        bus.memREN  = 1'b1;
        check_state("oor_c0", FREE);
        tick();
        check_state("oor_c1", ERROR);
        check("oor_load", bus.ramload, last_load);
        bus.memREN = 1'b0;
        tick();
        check_state("oor_c2", FREE);
`else
        do_read(32'h1000, 32'h5A5A0001, "wrap_rd");
`endif

        // Reset during the BUSY cycle of a write
        bus.memaddr  = 32'h8;
        bus.memstore = 32'hFFFF0000;
        bus.memWEN   = 1'b1;
        check_state("rw_c0", FREE);
        tick();
        check_state("rw_c1", BUSY);
        rst = 1'b1;
        tick();
        check_state("rw_c2", FREE);
        check("rw_load", bus.ramload, 32'h0);
        rst = 1'b0;
        bus.memWEN = 1'b0;
        tick();
        check_state("rw_c3", FREE);
        do_read(32'h8, 32'h22222222, "rw_rd");

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
